// File: rtl/regfile_writeback_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_writeback_arbiter_if
//
// Purpose : Bundles the writeback request bus (requesters -> arbiter) and the
//           register-file write-port bus (arbiter -> register file) used by
//           regfile_writeback_arbiter.
//
// Signals :
//   req_valid_in  [NUM_REQ]                   requester has a pending write
//   req_reg_in    [NUM_REQ][REG_ADDR_W]       destination register per requester
//   req_data_in   [NUM_REQ][DATA_W]           write data per requester
//   req_ready_out [NUM_REQ]                   same-cycle grant per requester
//   wr_en_out     [NUM_WR_PORTS]              register-file write enable per port
//   wr_reg_out    [NUM_WR_PORTS][REG_ADDR_W]  destination register per port
//   wr_data_out   [NUM_WR_PORTS][DATA_W]      write data per port
//
// Modports:
//   master : requester / register-file side (drives requests, observes grants/writes)
//   slave  : arbiter side
// -----------------------------------------------------------------------------
interface regfile_writeback_arbiter_if #(
    parameter int NUM_REQ      = 4,
    parameter int NUM_WR_PORTS = 2,
    parameter int DATA_W       = 32,
    parameter int REG_ADDR_W   = 5
);
    logic [NUM_REQ-1:0]                        req_valid_in;
    logic [NUM_REQ-1:0][REG_ADDR_W-1:0]        req_reg_in;
    logic [NUM_REQ-1:0][DATA_W-1:0]            req_data_in;
    logic [NUM_REQ-1:0]                        req_ready_out;
    logic [NUM_WR_PORTS-1:0]                   wr_en_out;
    logic [NUM_WR_PORTS-1:0][REG_ADDR_W-1:0]   wr_reg_out;
    logic [NUM_WR_PORTS-1:0][DATA_W-1:0]       wr_data_out;

    modport master (
        output req_valid_in,
        output req_reg_in,
        output req_data_in,
        input  req_ready_out,
        input  wr_en_out,
        input  wr_reg_out,
        input  wr_data_out
    );

    modport slave (
        input  req_valid_in,
        input  req_reg_in,
        input  req_data_in,
        output req_ready_out,
        output wr_en_out,
        output wr_reg_out,
        output wr_data_out
    );
endinterface

// File: rtl/regfile_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_writeback_arbiter
//
// Purpose : Arbitrates NUM_REQ functional-unit writeback streams onto the
//           NUM_WR_PORTS register-file write ports with round-robin fairness.
//           Requests to x0 are granted and absorbed without using a port.
//           A request whose register collides with an earlier grant in the
//           same cycle is deferred; the scan continues past it, so there is
//           no head-of-line blocking.
//
// Ports   :
//   clk_in            clock
//   rst_in            asynchronous, active-high reset
//   bus (slave)       request bus and register-file write ports
//                     (see regfile_writeback_arbiter_if)
//   stall_cycles_out  [31:0] cycles with an ungranted valid request (stats build)
//   grant_count_out   [31:0] total grants, x0 included (stats build)
//
// Configuration:
//   WB_ARB_STATS_EN   when defined, adds the two saturating statistics
//                     counters and their output ports. Arbitration is the
//                     same either way.
//
// Timing  : req_ready_out is combinational (same-cycle grant); the granted
//           write appears on wr_*_out one clock later.
// -----------------------------------------------------------------------------
module regfile_writeback_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int NUM_WR_PORTS = 2,
    parameter int DATA_W       = 32,
    parameter int REG_ADDR_W   = 5
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    regfile_writeback_arbiter_if.slave   bus
`ifdef WB_ARB_STATS_EN
    ,
    output logic [31:0]                  stall_cycles_out,
    output logic [31:0]                  grant_count_out
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Round-robin pointer: first requester visited by the scan.
    logic [PTR_W-1:0]                          r_rr_ptr;
    logic [PTR_W-1:0]                          w_rr_ptr_next;

    // Registered write-port outputs.
    logic [NUM_WR_PORTS-1:0]                   r_wr_en;
    logic [NUM_WR_PORTS-1:0][REG_ADDR_W-1:0]   r_wr_reg;
    logic [NUM_WR_PORTS-1:0][DATA_W-1:0]       r_wr_data;

    // Combinational scan results.
    logic [NUM_REQ-1:0]                        w_grant;
    logic [NUM_WR_PORTS-1:0]                   w_port_en;
    logic [NUM_WR_PORTS-1:0][REG_ADDR_W-1:0]   w_port_reg;
    logic [NUM_WR_PORTS-1:0][DATA_W-1:0]       w_port_data;

    // Scan temporaries.
    logic [PTR_W:0]                            w_scan_sum;
    logic [PTR_W-1:0]                          w_scan_idx;
    logic                                      w_conflict;
    logic                                      w_placed;

    // -------------------------------------------------------------------------
    // Round-robin scan. Ports fill strictly in order, so the first port with
    // w_port_en clear is the next free one, and the set of enabled ports is
    // exactly the set of non-x0 registers already granted this cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        w_grant       = '0;
        w_port_en     = '0;
        w_port_reg    = '0;
        w_port_data   = '0;
        w_rr_ptr_next = r_rr_ptr;
        w_scan_sum    = '0;
        w_scan_idx    = '0;
        w_conflict    = 1'b0;
        w_placed      = 1'b0;

        for (int s = 0; s < NUM_REQ; s++) begin
            // Requester index rr_ptr + s, wrapped modulo NUM_REQ.
            w_scan_sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(s);
            if (w_scan_sum >= (PTR_W+1)'(NUM_REQ)) begin
                w_scan_sum = w_scan_sum - (PTR_W+1)'(NUM_REQ);
            end
            w_scan_idx = w_scan_sum[PTR_W-1:0];

            if (bus.req_valid_in[w_scan_idx]) begin
                if (bus.req_reg_in[w_scan_idx] == '0) begin
                    // x0 write: always granted, consumes no port.
                    w_grant[w_scan_idx] = 1'b1;
                    w_rr_ptr_next = (w_scan_idx == PTR_W'(NUM_REQ - 1)) ? '0
                                                                         : w_scan_idx + 1'b1;
                end else begin
                    w_conflict = 1'b0;
                    for (int p = 0; p < NUM_WR_PORTS; p++) begin
                        if (w_port_en[p] && (w_port_reg[p] == bus.req_reg_in[w_scan_idx])) begin
                            w_conflict = 1'b1;
                        end
                    end

                    w_placed = 1'b0;
                    if (!w_conflict) begin
                        for (int p = 0; p < NUM_WR_PORTS; p++) begin
                            if (!w_placed && !w_port_en[p]) begin
                                w_port_en[p]   = 1'b1;
                                w_port_reg[p]  = bus.req_reg_in[w_scan_idx];
                                w_port_data[p] = bus.req_data_in[w_scan_idx];
                                w_placed       = 1'b1;
                            end
                        end
                    end

                    if (w_placed) begin
                        w_grant[w_scan_idx] = 1'b1;
                        w_rr_ptr_next = (w_scan_idx == PTR_W'(NUM_REQ - 1)) ? '0
                                                                             : w_scan_idx + 1'b1;
                    end
                end
            end
        end
    end

    // Grants are suppressed while reset is held so no requester sees a
    // transfer that the arbiter will discard.
    assign bus.req_ready_out = rst_in ? '0 : w_grant;

    // -------------------------------------------------------------------------
    // State: pointer and registered write ports. Unused ports carry zeros
    // because the scan defaults them to zero.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst_in) begin
            r_rr_ptr  <= '0;
            r_wr_en   <= '0;
            r_wr_reg  <= '0;
            r_wr_data <= '0;
        end else begin
            r_rr_ptr  <= w_rr_ptr_next;
            r_wr_en   <= w_port_en;
            r_wr_reg  <= w_port_reg;
            r_wr_data <= w_port_data;
        end
    end

    assign bus.wr_en_out   = r_wr_en;
    assign bus.wr_reg_out  = r_wr_reg;
    assign bus.wr_data_out = r_wr_data;

`ifdef WB_ARB_STATS_EN
    // -------------------------------------------------------------------------
    // Saturating statistics counters.
    // -------------------------------------------------------------------------
    logic [31:0] r_stall_cycles;
    logic [31:0] r_grant_count;
    logic        w_any_stall;
    logic [32:0] w_grant_sum;

    assign w_any_stall = |(bus.req_valid_in & ~w_grant);
    // One extra bit catches the carry so the count clamps instead of wrapping.
    assign w_grant_sum = {1'b0, r_grant_count} + 33'($countones(w_grant));

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_stall_cycles <= '0;
            r_grant_count  <= '0;
        end else begin
            if (w_any_stall && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            r_grant_count <= w_grant_sum[32] ? '1 : w_grant_sum[31:0];
        end
    end

    assign stall_cycles_out = r_stall_cycles;
    assign grant_count_out  = r_grant_count;
`endif

endmodule
